lc3_program_loader: RTL
=======================

# lc3_program_loader

Streams a program image into LC3 memory while holding the core in reset, then releases it. It writes memory where the simulation top-level reads it, so a bench or a host link can place code before execution starts. It sits between a 16-bit word source (UART deserializer or testbench driver) and the LC3 memory write port, and drives the core's reset. The image is `origin`, `count`, `count` data words, then a checksum word.

## Interface
- `MEMORY_WORDCOUNT`, default 256: number of words in LC3 memory; the legal address range is 0..MEMORY_WORDCOUNT-1.
- `ADDR_WIDTH`, default 8: width of `memAddr`; must satisfy 2^ADDR_WIDTH >= MEMORY_WORDCOUNT.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous; abandons the current load and returns to ORIGIN.
- `inData`  in  16  stream word.
- `inValid`  in  1  `inData` valid.
- `inReady`  out  1  loader can accept a word. A word is accepted on any edge where `inValid && inReady`.
- `memWriteEn`  out  1  one-cycle write strobe to LC3 memory.
- `memAddr`  out  ADDR_WIDTH  write address.
- `memWriteData`  out  16  write data.
- `coreReset_n`  out  1  active-low reset to the LC3 core; low until a load completes successfully.
- `loadDone`  out  1  image loaded and checksum matched.
- `loadError`  out  1  image rejected.

## Operation
- States: ORIGIN, COUNT, DATA, CHECK, RUN, ERROR. Reset enters ORIGIN.
- ORIGIN: accept a word, latch it as `origin` (16 bit), go to COUNT.
- COUNT: accept a word, latch it as `count` (16 bit).
  - Go to ERROR if `count == 0`, or `origin >= MEMORY_WORDCOUNT`, or `origin + count > MEMORY_WORDCOUNT`. The sum is evaluated at 17 bits, with no wrap.
  - Otherwise clear `index` and `sum`, then go to DATA.
- DATA: on each accepted word:
  - issue a write of the word to address `origin + index`;
  - `sum <= sum + word` (modulo 2^16);
  - `index <= index + 1`.
  - Go to CHECK after the word with `index == count-1`.
- CHECK: accept a word. If it equals `sum`, go to RUN; otherwise go to ERROR.
- RUN: `coreReset_n = 1`, `loadDone = 1`. Further stream words are not accepted.
- ERROR: `loadError = 1`, `coreReset_n = 0`. Further stream words are not accepted. No further memory writes.
- `inReady` = 1 in ORIGIN, COUNT, DATA and CHECK; 0 in RUN and ERROR. It is decoded from the state and does not depend on `inValid`.
- `restart` in any state:
  - next state is ORIGIN;
  - `loadDone`, `loadError`, `coreReset_n` and `memWriteEn` go to 0;
  - a word presented on the same edge is discarded.
  - `restart` has priority over acceptance.
- Memory words already written by an aborted or failed load are not cleared.

## Timing
- Reset values, applied asynchronously: state ORIGIN, `inReady` 1, `memWriteEn` 0, `memAddr` 0, `memWriteData` 0, `coreReset_n` 0, `loadDone` 0, `loadError` 0, `origin`/`count`/`index`/`sum` 0.
- Write latency is 1. A data word accepted on edge E drives `memWriteEn`, `memAddr` and `memWriteData` for exactly the cycle after E. These outputs are registered.
- Throughput: one word per cycle; back-to-back writes are allowed. Idle `inValid` cycles produce no strobe. `memAddr` and `memWriteData` hold their last value when `memWriteEn` = 0.
- The checksum word is accepted no earlier than the edge after the last data word. Therefore the final write strobe completes before `coreReset_n` rises.
- Checksum accepted on edge E: `coreReset_n`, `loadDone` (match) or `loadError` (mismatch) change right after E. `inReady` drops right after E.
- A bad `count` accepted on edge E: `loadError` = 1 and `inReady` = 0 right after E. No write strobes occur.
- `restart` sampled on edge E: `coreReset_n` is low right after E, and `inReady` = 1 right after E.
- `reset_n` asserted mid-load takes effect immediately, with no clock edge needed. Any pending write strobe is cancelled.
- `loadDone` and `loadError` are never 1 at the same time.

## Test plan
- **Good load.** Stream 0x0000, 0x0003, 0x1021, 0x5020, 0xF025, 0x5066 with `inValid` held high. Required: write strobes on three consecutive cycles at addresses 0, 1, 2 with data 0x1021, 0x5020, 0xF025. `coreReset_n` and `loadDone` go to 1 after the checksum edge. `inReady` = 0.
- **Bad checksum.** Same image with checksum 0x5067. Required: the three writes still occur, then `loadError` = 1, `loadDone` = 0 and `coreReset_n` stays 0. A further `inValid` is not accepted.
- **Range error.** With MEMORY_WORDCOUNT=256, stream origin 0x00FE and count 0x0003. Required: `loadError` = 1 after the count edge and no `memWriteEn`. Separately, origin 0x00FD with count 3 succeeds, writing 0xFD..0xFF. Count 0 gives an error.
- **Stall.** Good load with `inValid` toggling every other cycle. Required: one strobe per accepted word, contiguous addresses from origin 0x0010, and a correct checksum giving `loadDone` = 1.
- **Restart.** Pulse `restart` in RUN. Required: `coreReset_n` = 0 next cycle and `loadDone` = 0, and a following good load at origin 0x0020 completes. Pulse `restart` after the second of three data words. Required: the next word is treated as an origin.
- **Async reset.** Assert `reset_n` low between clock edges during DATA. Required: all outputs go to their reset values before the next edge, with no strobe afterwards. Then release and perform a good load.

Source files
------------

// File: rtl/lc3_program_loader.sv
// Purpose : streams an LC3 program image (origin, count, data words, checksum) into LC3
//           memory while holding the core in reset, then releases the core on a good checksum.
// Latency : a data word accepted on edge E is written (memWriteEn/memAddr/memWriteData) in the
//           cycle right after E; status outputs follow the state register with no extra delay.
// Backpressure: inReady is decoded from state only; high while loading, low in RUN and ERROR.
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   restart               synchronous abort; returns to ORIGIN, wins over word acceptance
//   inData/inValid/inReady  16-bit word stream, accepted on inValid && inReady
//   memWriteEn/memAddr/memWriteData  registered one-cycle write port into LC3 memory
//   coreReset_n           low until a load completes with a matching checksum
//   loadDone/loadError    image accepted / image rejected (mutually exclusive)
//
// ADDR_WIDTH must be at most 16: addresses are formed from the low bits of a 16-bit origin.

module lc3_program_loader #(
    parameter int MEMORY_WORDCOUNT = 256,
    parameter int ADDR_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  restart,
    input  logic [15:0]           inData,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  memWriteEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [15:0]           memWriteData,
    output logic                  coreReset_n,
    output logic                  loadDone,
    output logic                  loadError
);

    typedef enum logic [2:0] {
        S_ORIGIN,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    // Range checks are done at 17 bits so origin + count cannot wrap into a legal value.
    localparam logic [16:0] WORDCOUNT17 = 17'(MEMORY_WORDCOUNT);

    state_t                  state_q, state_d;
    logic [15:0]             origin_q, origin_d;
    logic [15:0]             count_q, count_d;
    logic [15:0]             index_q, index_d;
    logic [15:0]             sum_q, sum_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;

    logic                    accept;
    logic [16:0]             end_addr;
    logic                    range_bad;

    // Ready depends only on state so the source never sees a combinational loop through inValid.
    always_comb begin
        inReady = 1'b0;
        case (state_q)
            S_ORIGIN, S_COUNT, S_DATA, S_CHECK: inReady = 1'b1;
            default:                            inReady = 1'b0;
        endcase
    end

    assign accept    = inValid && inReady;
    assign end_addr  = {1'b0, origin_q} + {1'b0, inData};
    assign range_bad = (inData == 16'd0)
                    || ({1'b0, origin_q} >= WORDCOUNT17)
                    || (end_addr > WORDCOUNT17);

    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        count_d  = count_q;
        index_d  = index_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        if (restart) begin
            // Any word presented on this edge is dropped; no strobe is issued.
            state_d = S_ORIGIN;
        end else if (accept) begin
            case (state_q)
                S_ORIGIN: begin
                    origin_d = inData;
                    state_d  = S_COUNT;
                end
                S_COUNT: begin
                    count_d = inData;
                    if (range_bad) begin
                        state_d = S_ERROR;
                    end else begin
                        index_d = 16'd0;
                        sum_d   = 16'd0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    we_d    = 1'b1;
                    addr_d  = origin_q[ADDR_WIDTH-1:0] + index_q[ADDR_WIDTH-1:0];
                    wdata_d = inData;
                    sum_d   = sum_q + inData;
                    index_d = index_q + 16'd1;
                    if (index_q == (count_q - 16'd1)) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = (inData == sum_q) ? S_RUN : S_ERROR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_ORIGIN;
            origin_q <= 16'd0;
            count_q  <= 16'd0;
            index_q  <= 16'd0;
            sum_q    <= 16'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            count_q  <= count_d;
            index_q  <= index_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign memWriteEn   = we_q;
    assign memAddr      = addr_q;
    assign memWriteData = wdata_q;

    // Status outputs are pure decodes of the state register, so they are glitch-free and
    // loadDone/loadError can never be high together.
    assign coreReset_n  = (state_q == S_RUN);
    assign loadDone     = (state_q == S_RUN);
    assign loadError    = (state_q == S_ERROR);

endmodule
